// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer and the decode unit.
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // ADDI x0,x0,0 - the canonical bubble inserted by flushes
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/perf_counter.sv
// Wrapping enable counter with synchronous reset, used for performance statistics.
module perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            r_count <= '0;
        else if (en_i)
            r_count <= r_count + WIDTH'(1);
    end

    assign count_o = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the F/D/E/M/W pipeline with init, FENCE drain and EBREAK halt.
//   state    | meaning
//   ST_INIT  | forced flush of all stages after reset
//   ST_RUN   | normal hazard/redirect arbitration
//   ST_DRAIN | FENCE held in E until M and W are empty
//   ST_HALT  | EBREAK halt, waiting for debug resume
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int INIT_CYCLES = 3,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 dataHazard_i,
    input  logic                 D_predictPC_i,
    input  logic                 E_redirect_i,
    input  logic                 E_busy_i,
    input  logic                 M_busy_i,
    input  logic                 DE_isFENCE_i,
    input  logic                 DE_isEBREAK_i,
    input  logic                 M_nop_i,
    input  logic                 W_nop_i,
    input  logic                 resume_i,
    output logic                 F_stall_o,
    output logic                 D_stall_o,
    output logic                 E_stall_o,
    output logic                 M_stall_o,
    output logic                 F_flush_o,
    output logic                 D_flush_o,
    output logic                 E_flush_o,
    output logic                 M_flush_o,
    output logic                 F_takeD_o,
    output logic                 F_takeE_o,
    output logic                 halted_o,
    output logic [CNT_WIDTH-1:0] stallCycles_o,
    output logic [CNT_WIDTH-1:0] redirectCount_o
);

    localparam int            IW        = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [IW-1:0] INIT_LOAD = IW'(INIT_CYCLES - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_init_cnt;
    logic            r_fence_done;
    logic            w_drain_done;

    // The drained FENCE is still in E on the first RUN cycle; it must advance, not re-drain.
    assign w_drain_done = M_nop_i & W_nop_i & ~M_busy_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= ST_INIT;
            r_init_cnt   <= INIT_LOAD;
            r_fence_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT && r_init_cnt != '0)
                r_init_cnt <= r_init_cnt - IW'(1);
            if (r_state == ST_DRAIN && w_drain_done)
                r_fence_done <= 1'b1;
            else if (r_state == ST_RUN && !(M_busy_i || E_busy_i))
                r_fence_done <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        F_stall_o   = 1'b0;
        D_stall_o   = 1'b0;
        E_stall_o   = 1'b0;
        M_stall_o   = 1'b0;
        F_flush_o   = 1'b0;
        D_flush_o   = 1'b0;
        E_flush_o   = 1'b0;
        M_flush_o   = 1'b0;
        F_takeD_o   = 1'b0;
        F_takeE_o   = 1'b0;
        halted_o    = 1'b0;
        case (r_state)
            ST_INIT: begin
                F_flush_o = 1'b1;
                D_flush_o = 1'b1;
                E_flush_o = 1'b1;
                M_flush_o = 1'b1;
                if (r_init_cnt == '0)
                    w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (M_busy_i) begin
                    F_stall_o = 1'b1;
                    D_stall_o = 1'b1;
                    E_stall_o = 1'b1;
                    M_stall_o = 1'b1;
                end else if (E_busy_i) begin
                    F_stall_o = 1'b1;
                    D_stall_o = 1'b1;
                    E_stall_o = 1'b1;
                    M_flush_o = 1'b1;
                end else if (E_redirect_i) begin
                    F_flush_o = 1'b1;
                    D_flush_o = 1'b1;
                    E_flush_o = 1'b1;
                    F_takeE_o = 1'b1;
                end else if (dataHazard_i) begin
                    F_stall_o = 1'b1;
                    D_stall_o = 1'b1;
                    E_flush_o = 1'b1;
                end else if (D_predictPC_i) begin
                    F_flush_o = 1'b1;
                    F_takeD_o = 1'b1;
                end
                if (!(M_busy_i || E_busy_i)) begin
                    if (DE_isFENCE_i && !r_fence_done)
                        w_state_nxt = ST_DRAIN;
                    else if (DE_isEBREAK_i)
                        w_state_nxt = ST_HALT;
                end
            end
            ST_DRAIN: begin
                F_stall_o = 1'b1;
                D_stall_o = 1'b1;
                E_stall_o = 1'b1;
                M_flush_o = 1'b1;
                if (w_drain_done)
                    w_state_nxt = ST_RUN;
            end
            ST_HALT: begin
                F_stall_o = 1'b1;
                D_stall_o = 1'b1;
                E_flush_o = 1'b1;
                halted_o  = 1'b1;
                if (resume_i)
                    w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    perf_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (D_stall_o),
        .count_o (stallCycles_o)
    );

    perf_counter #(.WIDTH(CNT_WIDTH)) u_redirect_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (F_takeE_o),
        .count_o (redirectCount_o)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl with hand-computed control vectors.
module tb_pipeline_ctrl;

    // control vector bit order: F_stall D_stall E_stall M_stall F_flush D_flush E_flush M_flush F_takeD F_takeE halted
    localparam logic [10:0] C_IDLE  = 11'b0000_0000_000;
    localparam logic [10:0] C_INIT  = 11'b0000_1111_000;
    localparam logic [10:0] C_MBUSY = 11'b1111_0000_000;
    localparam logic [10:0] C_EBUSY = 11'b1110_0001_000;
    localparam logic [10:0] C_DRAIN = 11'b1110_0001_000;
    localparam logic [10:0] C_REDIR = 11'b0000_1110_010;
    localparam logic [10:0] C_HAZ   = 11'b1100_0010_000;
    localparam logic [10:0] C_PRED  = 11'b0000_1000_100;
    localparam logic [10:0] C_HALT  = 11'b1100_0010_001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_i, dataHazard_i, D_predictPC_i, E_redirect_i, E_busy_i, M_busy_i;
    logic DE_isFENCE_i, DE_isEBREAK_i, M_nop_i, W_nop_i, resume_i;
    logic F_stall_o, D_stall_o, E_stall_o, M_stall_o;
    logic F_flush_o, D_flush_o, E_flush_o, M_flush_o;
    logic F_takeD_o, F_takeE_o, halted_o;
    logic [31:0] stallCycles_o, redirectCount_o;
    logic [10:0] w_ctl;

    int n_total = 0;
    int n_pass  = 0;

    pipeline_ctrl #(.INIT_CYCLES(3), .CNT_WIDTH(32)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .dataHazard_i    (dataHazard_i),
        .D_predictPC_i   (D_predictPC_i),
        .E_redirect_i    (E_redirect_i),
        .E_busy_i        (E_busy_i),
        .M_busy_i        (M_busy_i),
        .DE_isFENCE_i    (DE_isFENCE_i),
        .DE_isEBREAK_i   (DE_isEBREAK_i),
        .M_nop_i         (M_nop_i),
        .W_nop_i         (W_nop_i),
        .resume_i        (resume_i),
        .F_stall_o       (F_stall_o),
        .D_stall_o       (D_stall_o),
        .E_stall_o       (E_stall_o),
        .M_stall_o       (M_stall_o),
        .F_flush_o       (F_flush_o),
        .D_flush_o       (D_flush_o),
        .E_flush_o       (E_flush_o),
        .M_flush_o       (M_flush_o),
        .F_takeD_o       (F_takeD_o),
        .F_takeE_o       (F_takeE_o),
        .halted_o        (halted_o),
        .stallCycles_o   (stallCycles_o),
        .redirectCount_o (redirectCount_o)
    );

    assign w_ctl = {F_stall_o, D_stall_o, E_stall_o, M_stall_o,
                    F_flush_o, D_flush_o, E_flush_o, M_flush_o,
                    F_takeD_o, F_takeE_o, halted_o};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic ctl(input string tag, input logic [10:0] exp);
        #1;
        chk(tag, {21'd0, w_ctl}, {21'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dataHazard_i  = 1'b0;
        D_predictPC_i = 1'b0;
        E_redirect_i  = 1'b0;
        E_busy_i      = 1'b0;
        M_busy_i      = 1'b0;
        DE_isFENCE_i  = 1'b0;
        DE_isEBREAK_i = 1'b0;
        M_nop_i       = 1'b0;
        W_nop_i       = 1'b0;
        resume_i      = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;

        // INIT: three flush cycles, requests ignored
        E_redirect_i = 1'b1; M_busy_i = 1'b1; dataHazard_i = 1'b1; D_predictPC_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ctl($sformatf("init_ctl_%0d", i), C_INIT);
            tick();
        end
        chk("init_stall_cnt", stallCycles_o, 32'd0);
        chk("init_redir_cnt", redirectCount_o, 32'd0);
        clear_inputs();
        ctl("run_idle", C_IDLE);
        tick();

        // data hazard beats decode prediction, then prediction accepted
        dataHazard_i = 1'b1; D_predictPC_i = 1'b1;
        ctl("hazard", C_HAZ);
        tick();
        dataHazard_i = 1'b0;
        ctl("predict", C_PRED);
        chk("stall_cnt_1", stallCycles_o, 32'd1);
        tick();
        clear_inputs();

        // redirect overrides hazard
        E_redirect_i = 1'b1; dataHazard_i = 1'b1;
        ctl("redirect", C_REDIR);
        tick();
        clear_inputs();
        chk("redir_cnt_1", redirectCount_o, 32'd1);
        chk("stall_cnt_after_redir", stallCycles_o, 32'd1);

        // memory busy blocks redirect for four cycles
        E_redirect_i = 1'b1; M_busy_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ctl($sformatf("mbusy_%0d", i), C_MBUSY);
            tick();
        end
        M_busy_i = 1'b0;
        ctl("redirect_after_mbusy", C_REDIR);
        chk("stall_cnt_5", stallCycles_o, 32'd5);
        chk("redir_cnt_still_1", redirectCount_o, 32'd1);
        tick();
        chk("redir_cnt_2", redirectCount_o, 32'd2);
        clear_inputs();

        // execute busy beats redirect
        E_busy_i = 1'b1; E_redirect_i = 1'b1;
        ctl("ebusy", C_EBUSY);
        tick();
        clear_inputs();
        chk("stall_cnt_6", stallCycles_o, 32'd6);
        chk("redir_cnt_held", redirectCount_o, 32'd2);

        // FENCE while M busy waits in RUN, then drains for three cycles
        DE_isFENCE_i = 1'b1; M_busy_i = 1'b1;
        ctl("fence_mbusy", C_MBUSY);
        tick();
        M_busy_i = 1'b0;
        ctl("fence_run", C_IDLE);
        tick();
        ctl("drain_1", C_DRAIN);
        tick();
        ctl("drain_2", C_DRAIN);
        tick();
        M_nop_i = 1'b1; W_nop_i = 1'b1;
        ctl("drain_3", C_DRAIN);
        tick();
        ctl("fence_advance", C_IDLE);
        tick();
        clear_inputs();
        ctl("post_fence_run", C_IDLE);
        chk("stall_cnt_10", stallCycles_o, 32'd10);

        // FENCE with empty M/W drains for exactly one cycle
        DE_isFENCE_i = 1'b1; M_nop_i = 1'b1; W_nop_i = 1'b1;
        ctl("fence2_run", C_IDLE);
        tick();
        ctl("drain_single", C_DRAIN);
        tick();
        DE_isFENCE_i = 1'b0;
        ctl("drain_single_exit", C_IDLE);
        chk("stall_cnt_11", stallCycles_o, 32'd11);
        tick();
        clear_inputs();

        // EBREAK halt and resume
        DE_isEBREAK_i = 1'b1;
        ctl("ebreak_run", C_IDLE);
        tick();
        DE_isEBREAK_i = 1'b0;
        ctl("halt_1", C_HALT);
        tick();
        ctl("halt_2", C_HALT);
        tick();
        resume_i = 1'b1;
        ctl("halt_resume", C_HALT);
        tick();
        resume_i = 1'b0;
        ctl("resumed_run", C_IDLE);
        chk("stall_cnt_14", stallCycles_o, 32'd14);
        tick();

        // reset during HALT
        DE_isEBREAK_i = 1'b1;
        tick();
        DE_isEBREAK_i = 1'b0;
        ctl("halt_again", C_HALT);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        ctl("reset_from_halt", C_INIT);
        chk("reset_stall_cnt", stallCycles_o, 32'd0);
        chk("reset_redir_cnt", redirectCount_o, 32'd2 - 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
